// File: rtl/cp0_exc_handler_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions.
package cp0_exc_handler_pkg;

    localparam logic [4:0] RegSr    = 5'd12;
    localparam logic [4:0] RegCause = 5'd13;
    localparam logic [4:0] RegEpc   = 5'd14;
    localparam logic [4:0] RegPrid  = 5'd15;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdel = 5'd4,
        ExcAdes = 5'd5,
        ExcRi   = 5'd10,
        ExcOv   = 5'd12
    } exc_code_e;

    localparam logic [31:0] HandlerEntry = 32'h0000_4180;

    localparam int unsigned SrIeBit    = 0;
    localparam int unsigned SrExlBit   = 1;
    localparam int unsigned SrImLo     = 10;
    localparam int unsigned CauseBdBit = 31;
    localparam int unsigned CauseIpLo  = 10;
    localparam int unsigned CauseExcLo = 2;

    // A faulting delay-slot instruction must restart at its branch.
    function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] ret_pc;
        ret_pc = bd ? pc - 32'd4 : pc;
        return {ret_pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_exc_handler.sv
// Coprocessor 0: SR/Cause/EPC/PRId, mtc0/mfc0/eret, and the M-stage interrupt/exception decision.
module cp0_exc_handler
    import cp0_exc_handler_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h0000_0007,
    parameter int unsigned HWINT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_m,
    input  logic [4:0]         exc_m,
    input  logic               bd_m,
    input  logic [HWINT_W-1:0] hwint,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               eret_m,
    output logic [31:0]        rdata,
    output logic               intexc,
    output logic [31:0]        epc
);

    logic               sr_ie_q, sr_ie_d;
    logic               sr_exl_q, sr_exl_d;
    logic [HWINT_W-1:0] sr_im_q, sr_im_d;
    logic               cause_bd_q, cause_bd_d;
    logic [HWINT_W-1:0] cause_ip_q, cause_ip_d;
    logic [4:0]         cause_exc_q, cause_exc_d;
    logic [31:0]        epc_q, epc_d;

    logic int_req;
    logic exc_req;

    assign int_req = (|(hwint & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (exc_m != 5'd0) & ~sr_exl_q;
    assign intexc  = int_req | exc_req;
    assign epc     = epc_q;

    // Priority: intexc, then eret, then mtc0.
    always_comb begin
        sr_ie_d     = sr_ie_q;
        sr_exl_d    = sr_exl_q;
        sr_im_d     = sr_im_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hwint;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (intexc) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bd_m;
            cause_exc_d = int_req ? ExcInt : exc_m;
            epc_d       = exc_epc(pc_m, bd_m);
        end else if (eret_m) begin
            sr_exl_d = 1'b0;
        end else if (we) begin
            if (addr == RegSr) begin
                sr_ie_d  = wdata[SrIeBit];
                sr_exl_d = wdata[SrExlBit];
                sr_im_d  = wdata[SrImLo +: HWINT_W];
            end else if (addr == RegEpc) begin
                epc_d = {wdata[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_ie_q     <= 1'b0;
            sr_exl_q    <= 1'b0;
            sr_im_q     <= '0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_ie_q     <= sr_ie_d;
            sr_exl_q    <= sr_exl_d;
            sr_im_q     <= sr_im_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    logic [31:0] sr_word;
    logic [31:0] cause_word;

    always_comb begin
        sr_word                            = 32'd0;
        sr_word[SrIeBit]                   = sr_ie_q;
        sr_word[SrExlBit]                  = sr_exl_q;
        sr_word[SrImLo +: HWINT_W]         = sr_im_q;
        cause_word                         = 32'd0;
        cause_word[CauseBdBit]             = cause_bd_q;
        cause_word[CauseIpLo +: HWINT_W]   = cause_ip_q;
        cause_word[CauseExcLo +: 5]        = cause_exc_q;
    end

    // Reads show pre-edge state; a same-cycle mtc0 is not bypassed.
    always_comb begin
        case (addr)
            RegSr:    rdata = sr_word;
            RegCause: rdata = cause_word;
            RegEpc:   rdata = epc_q;
            RegPrid:  rdata = PRID;
            default:  rdata = 32'd0;
        endcase
    end

endmodule
